// File: rtl/xoodoo_permute_pkg.sv
// Shared constants, round-constant table, FSM encoding and lane rotate helper
// for the Xoodoo permutation.
package xoodoo_permute_pkg;

    localparam int unsigned STATE_W    = 384;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned MAX_ROUNDS = 12;
    localparam int unsigned RC_W       = 12;

    localparam logic [RC_W-1:0] RC_TABLE [MAX_ROUNDS] = '{
        12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
        12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v,
                                               input int unsigned n);
        return (v << n) | (v >> (LANE_W - n));
    endfunction

endpackage

// File: rtl/xoodoo_permute_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
// Lane (y, x) sits at bits [128*y + 32*x +: 32].
module xoodoo_round
    import xoodoo_permute_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [LANE_W-1:0]  rc,
    output logic [STATE_W-1:0] state_out
);

    logic [2:0][3:0][LANE_W-1:0] a, t, w, c, r;
    logic [3:0][LANE_W-1:0]      p, e;

    assign a = state_in;

    for (genvar gx = 0; gx < 4; gx++) begin : g_col
        localparam int unsigned XM1 = (gx + 3) % 4;
        localparam int unsigned XM2 = (gx + 2) % 4;

        assign p[gx] = a[0][gx] ^ a[1][gx] ^ a[2][gx];
        assign e[gx] = rotl(p[XM1], 5) ^ rotl(p[XM1], 14);

        assign t[0][gx] = a[0][gx] ^ e[gx];
        assign t[1][gx] = a[1][gx] ^ e[gx];
        assign t[2][gx] = a[2][gx] ^ e[gx];

        // Iota folds into the plane-0 column 0 lane on the way out of rho-west.
        if (gx == 0) begin : g_iota
            assign w[0][gx] = t[0][gx] ^ rc;
        end else begin : g_no_iota
            assign w[0][gx] = t[0][gx];
        end
        assign w[1][gx] = t[1][XM1];
        assign w[2][gx] = rotl(t[2][gx], 11);

        assign c[0][gx] = w[0][gx] ^ (~w[1][gx] & w[2][gx]);
        assign c[1][gx] = w[1][gx] ^ (~w[2][gx] & w[0][gx]);
        assign c[2][gx] = w[2][gx] ^ (~w[0][gx] & w[1][gx]);

        assign r[0][gx] = c[0][gx];
        assign r[1][gx] = rotl(c[1][gx], 1);
        assign r[2][gx] = rotl(c[2][XM2], 8);
    end

    assign state_out = r;

endmodule

// File: rtl/xoodoo_permute.sv
// Iterative Xoodoo permutation: one round per cycle through a shared round
// core, with a registered result and a one-cycle done pulse.
module xoodoo_permute
    import xoodoo_permute_pkg::*;
#(
    parameter int unsigned NROUNDS = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               done,
    output logic               busy
);

    state_t               state, state_nxt;
    logic [3:0]           round_cnt;
    logic [3:0]           rc_idx;
    logic [LANE_W-1:0]    rc;
    logic                 last_round;
    logic [STATE_W-1:0]   work;
    logic [STATE_W-1:0]   round_out;

    // Short runs use the tail of the constant table.
    assign rc_idx     = 4'(MAX_ROUNDS - NROUNDS) + round_cnt;
    assign rc         = {{(LANE_W - RC_W){1'b0}}, RC_TABLE[rc_idx]};
    assign last_round = (round_cnt == 4'(NROUNDS - 1));

    xoodoo_round u_round (
        .state_in  (work),
        .rc        (rc),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_round) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (!reset) begin
            busy = (state != IDLE);
            done = (state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work      <= '0;
            state_out <= '0;
            round_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work      <= state_in;
                        round_cnt <= '0;
                    end
                end
                RUN: begin
                    work      <= round_out;
                    round_cnt <= round_cnt + 4'd1;
                    if (last_round) begin
                        state_out <= round_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xoodoo_permute.sv
// Directed bench for xoodoo_permute: 1-round and 12-round instances checked
// against hand-derived constants and a behavioural Xoodoo reference.
module tb_xoodoo_permute;

    logic         clk = 1'b0;
    logic         reset;
    logic         start12, start1;
    logic [383:0] in12, in1;
    logic [383:0] out12, out1;
    logic         done12, done1, busy12, busy1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xoodoo_permute dut12 (
        .clk(clk), .reset(reset), .start(start12), .state_in(in12),
        .state_out(out12), .done(done12), .busy(busy12)
    );

    xoodoo_permute #(.NROUNDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .state_in(in1),
        .state_out(out1), .done(done1), .busy(busy1)
    );

    localparam logic [11:0] REF_RC [12] = '{
        12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
        12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012
    };

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [383:0] xoodoo_ref(input logic [383:0] s, input int nr);
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] o;
        for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
        for (int r = 12 - nr; r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
            for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
            for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
            b = a;
            for (int x = 0; x < 4; x++) begin
                b[4+x] = a[4+(x+3)%4];
                b[8+x] = rl(a[8+x], 11);
            end
            b[0] = b[0] ^ {20'd0, REF_RC[r]};
            for (int x = 0; x < 4; x++) begin
                a[x]   = b[x]   ^ (~b[4+x] & b[8+x]);
                a[4+x] = b[4+x] ^ (~b[8+x] & b[x]);
                a[8+x] = b[8+x] ^ (~b[x]   & b[4+x]);
            end
            b = a;
            for (int x = 0; x < 4; x++) begin
                b[4+x] = rl(a[4+x], 1);
                b[8+x] = rl(a[8+(x+2)%4], 8);
            end
            a = b;
        end
        for (int i = 0; i < 12; i++) o[32*i +: 32] = a[i];
        return o;
    endfunction

    function automatic logic [383:0] rand_state();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [383:0] last_exp = '0;

    // Start the 12-round instance with v, optionally re-pulsing start with alt
    // at RUN cycles 3 and 7; expected result is the permutation of model_in.
    task automatic run12(input logic [383:0] v, input logic [383:0] model_in,
                         input bit repulse, input logic [383:0] alt, input string tag);
        int n;
        int busy_n;
        logic [383:0] exp;
        exp = xoodoo_ref(model_in, 12);
        start12 = 1'b1;
        in12    = v;
        tick();
        n = 1;
        busy_n = 0;
        while (!done12 && n < 40) begin
            if (busy12) busy_n++;
            if (n == 5) chk({tag, " out_held_in_run"}, out12, last_exp);
            if (repulse && (n == 3 || n == 7)) begin
                start12 = 1'b1;
                in12    = alt;
            end else begin
                start12 = 1'b0;
            end
            tick();
            n++;
        end
        start12 = 1'b0;
        if (busy12) busy_n++;
        chk_int({tag, " latency"}, n, 13);
        chk_int({tag, " within_window"}, int'(n <= 23), 1);
        chk_int({tag, " busy_cycles"}, busy_n, 13);
        chk({tag, " result"}, out12, exp);
        tick();
        chk_int({tag, " done_one_cycle"}, int'(done12), 0);
        chk_int({tag, " busy_low_idle"}, int'(busy12), 0);
        chk({tag, " out_held_idle"}, out12, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [383:0] v, v2, exp1;
        int pulses;

        reset   = 1'b1;
        start12 = 1'b0;
        start1  = 1'b0;
        in12    = '0;
        in1     = '0;
        tick();
        tick();
        chk_int("reset busy", int'(busy12), 0);
        chk_int("reset done", int'(done12), 0);
        chk("reset state_out", out12, '0);
        chk("reset state_out r1", out1, '0);

        // Reset wins over a simultaneous start.
        start12 = 1'b1;
        in12    = rand_state();
        tick();
        reset   = 1'b0;
        start12 = 1'b0;
        chk_int("reset_over_start busy", int'(busy12), 0);
        tick();
        chk_int("reset_over_start idle", int'(busy12), 0);

        // One round of the zero state: only lanes (0,0) and (1,0) are non-zero.
        exp1 = '0;
        exp1[31:0]    = 32'h00000012;
        exp1[159:128] = 32'h00000024;
        start1 = 1'b1;
        in1    = '0;
        tick();
        start1 = 1'b0;
        in1    = rand_state();
        chk_int("r1 run busy", int'(busy1), 1);
        chk_int("r1 run done", int'(done1), 0);
        tick();
        chk_int("r1 done at 2", int'(done1), 1);
        chk("r1 zero result", out1, exp1);
        tick();
        chk_int("r1 done cleared", int'(done1), 0);
        chk("r1 result held", out1, exp1);

        v = rand_state();
        start1 = 1'b1;
        in1    = v;
        tick();
        start1 = 1'b0;
        tick();
        chk_int("r1 rand done", int'(done1), 1);
        chk("r1 rand result", out1, xoodoo_ref(v, 1));

        v = rand_state();
        run12(v, v, 1'b0, '0, "rand_a");
        v = '0;
        run12(v, v, 1'b0, '0, "zero");

        v  = rand_state();
        v2 = rand_state();
        run12(v, v, 1'b1, v2, "repulse");

        // Abort mid-run: reset at round 6, no done pulse may follow.
        v = rand_state();
        start12 = 1'b1;
        in12    = v;
        tick();
        start12 = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_int("abort busy", int'(busy12), 0);
        chk_int("abort done", int'(done12), 0);
        chk("abort state_out", out12, '0);
        pulses = 0;
        repeat (20) begin
            tick();
            if (done12) pulses++;
        end
        chk_int("abort no done", pulses, 0);
        last_exp = '0;
        run12(v, v, 1'b0, '0, "after_abort");

        // Hash-controller style chaining: feed state_out back as state_in.
        for (int k = 0; k < 3; k++) begin
            run12(out12, last_exp, 1'b0, '0, $sformatf("chain%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xoodoo_permute.md
XOODOO_PERMUTE -- requirements
Module: xoodoo_permute

Interface
REQ-001 The block SHALL have parameter NROUNDS, default 12, giving the number of rounds run per invocation (legal range 1..12).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to permute state_in, sampled on the rising edge.
REQ-005 The block SHALL have port state_in, input, 384, the permutation input, sampled in the cycle start is high.
REQ-006 The block SHALL have port state_out, output, 384, the permuted state, held until the next accepted start.
REQ-007 The block SHALL have port done, output, 1, a one-cycle pulse marking state_out valid.
REQ-008 The block SHALL have port busy, output, 1, high while a permutation is in progress.

Function
REQ-009 The block SHALL map lane (plane y, column x) to bits [128*y+32*x +: 32], with byte 0 at bits [7:0], matching the hash controller's state layout.
REQ-010 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE after NROUNDS rounds, DONE->IDLE unconditionally.
REQ-011 An accepted start SHALL load state_in into the working register and clear the round counter (4 bits).
REQ-012 In RUN, each cycle SHALL apply one round, increment the round counter and select constant RC[12-NROUNDS+counter].
REQ-013 The round constants SHALL be, in order: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
REQ-014 Each round SHALL apply the following steps in order: theta, rho-west, iota, chi, rho-east (REQ-015..REQ-019).
REQ-015 Theta: P=A0^A1^A2; E[x]=rotl(P[x-1],5)^rotl(P[x-1],14); every lane Ay[x]^=E[x]; x indices mod 4.
REQ-016 Rho-west: A1[x]=A1[x-1]; A2[x]=rotl(A2[x],11).
REQ-017 Iota: A0[0]^=RC, zero-extended to 32 bits.
REQ-018 Chi: A0^=~A1&A2, A1^=~A2&A0 and A2^=~A0&A1, all computed from pre-chi values.
REQ-019 Rho-east: A1[x]=rotl(A1[x],1); A2[x]=rotl(A2[x-2],8).
REQ-020 state_out SHALL update on the edge that ends the last round; done SHALL be high for exactly one cycle, in DONE, with start-to-done latency of NROUNDS+1 cycles (13 by default).
REQ-021 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-022 A start while busy is high SHALL be ignored.
REQ-023 A start in the cycle after done (IDLE) SHALL be accepted, giving back-to-back operation with one idle cycle.
REQ-024 state_out SHALL be a stable register output, with no combinational path from state_in or start.

Reset
REQ-025 While reset is high, the FSM SHALL be forced to IDLE and the round counter cleared.
REQ-026 While reset is high, state_out and the working register SHALL be forced to 0, and done and busy to 0.
REQ-027 Reset SHALL override start in the same cycle.
REQ-028 Reset asserted mid-RUN SHALL abort the permutation without producing a done pulse.

Structure
REQ-029 A shared package SHALL hold STATE_W=384, LANE_W=32, MAX_ROUNDS=12, the round-constant table and the FSM state enumeration.
REQ-030 One round SHALL be a purely combinational sub-module, xoodoo_round (state, rc -> state), instantiated once and iterated.

Verification
REQ-031 With NROUNDS=1 and start with state_in=0: done after 2 cycles; state_out[31:0]=0x00000012, [159:128]=0x00000024, all other bits 0.
REQ-032 With NROUNDS=12, random state_in: state_out SHALL match a software Xoodoo model; done exactly 13 cycles after start; busy high for 13 cycles.
REQ-033 start re-pulsed at cycles 3 and 7 of RUN with a different state_in: it is ignored, and the result equals the first input's permutation.
REQ-034 reset asserted at round 6: next cycle busy=0, done=0 and state_out=0; no done pulse follows; a fresh start then gives the correct result.
REQ-035 Hash-controller handshake (start=xoodoo_enable, state_in=state_out): done arrives within the controller's 23-cycle XOODOO window, and state_out is stable until the next start.
